// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, reset defaults
// and instruction field positions (kept aligned with the control decoder's field set).
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          TIMEOUT_DEFAULT  = 16;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int TGT_MSB   = 25;
    localparam int TGT_LSB   = 0;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [31:0] instr);
        return {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Bus bundle between the fetch unit (master) and its memory/execute neighbours (slave).
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc_out;
    logic        instr_ack;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        zero;
    logic        fault;
    logic [15:0] retired;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, funct, pc_out, fault, retired,
        input  imem_ready, imem_rdata, instr_ack, stall, branch, jump, zero
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, funct, pc_out, fault, retired,
        output imem_ready, imem_rdata, instr_ack, stall, branch, jump, zero
    );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jump target, taken branch, or sequential pc+4.
module next_pc_sel
    import ifetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_branch,
    input  logic        i_zero,
    input  logic        i_jump,
    output logic [31:0] o_next_pc
);
    logic [31:0] w_pc4;
    logic        w_unused;

    assign w_pc4    = i_pc + 32'd4;
    assign w_unused = &{1'b0, i_instr[OP_MSB:OP_LSB]};

    // if/else rather than ?: so an unknown control bit falls through to pc+4.
    always_comb begin
        o_next_pc = w_pc4;
        if (i_jump) begin
            o_next_pc = {w_pc4[31:28], i_instr[TGT_MSB:TGT_LSB], 2'b00};
        end else if (i_branch && i_zero) begin
            o_next_pc = w_pc4 + branch_offset(i_instr);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: requests a word at pc, holds it for execute, then advances pc.
// state | meaning
// IDLE  | one dead cycle after reset before the first request
// FETCH | imem_req high, waiting for imem_ready (bounded by TIMEOUT)
// HOLD  | instruction presented, waiting for instr_ack without stall
// FAULT | fetch timed out; sticky until reset
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);
    localparam logic [31:0] PC_INIT  = {RESET_PC[31:2], 2'b00};
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [15:0]  r_tmo;
    logic [15:0]  r_retired;
    logic [31:0]  w_next_pc;
    logic         w_latch;
    logic         w_retire;
    logic         w_tmo_hit;

    assign w_latch   = (r_state == ST_FETCH) && bus.imem_ready;
    assign w_retire  = (r_state == ST_HOLD) && bus.instr_ack && !bus.stall;
    assign w_tmo_hit = (r_state == ST_FETCH) && !bus.imem_ready && (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (w_latch) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (w_retire) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        bus.fault       = 1'b0;
        case (r_state)
            ST_FETCH: bus.imem_req    = 1'b1;
            ST_HOLD:  bus.instr_valid = 1'b1;
            ST_FAULT: bus.fault       = 1'b1;
            default:  ;
        endcase
    end

    // Timeout count sits at zero outside FETCH, so every entry to FETCH starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= PC_INIT;
            r_instr   <= 32'd0;
            r_tmo     <= 16'd0;
            r_retired <= 16'd0;
        end else begin
            if (r_state != ST_FETCH) begin
                r_tmo <= 16'd0;
            end else if (!bus.imem_ready) begin
                r_tmo <= r_tmo + 16'd1;
            end
            if (w_latch) begin
                r_instr <= bus.imem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    next_pc_sel u_next_pc_sel (
        .i_pc      (r_pc),
        .i_instr   (r_instr),
        .i_branch  (bus.branch),
        .i_zero    (bus.zero),
        .i_jump    (bus.jump),
        .o_next_pc (w_next_pc)
    );

    assign bus.imem_addr = r_pc;
    assign bus.pc_out    = r_pc;
    assign bus.instr     = r_instr;
    assign bus.op        = r_instr[OP_MSB:OP_LSB];
    assign bus.funct     = r_instr[FUNCT_MSB:FUNCT_LSB];
    assign bus.retired   = r_retired;
endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: driver pushes expected fetch addresses and held words,
// an independent monitor pops and compares them as the DUT presents them.
module tb_ifetch_unit;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int          TMO     = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } hold_t;

    logic clk;
    logic rst_n;
    logic rst2_n;
    int   tests;
    int   fails;

    logic [31:0] fetch_q[$];
    hold_t       hold_q[$];
    logic [31:0] model_pc;
    logic [15:0] retired_m;

    ifetch_unit_if bus();
    ifetch_unit_if bus2();

    ifetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ifetch_unit #(.RESET_PC(32'h1000_000B), .TIMEOUT(TMO)) u_dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference next-PC, written straight from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                               input bit br, input bit jp, input bit z);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        off = $signed(w[15:0]);
        if (jp) return {pc4[31:28], w[25:0], 2'b00};
        if (br && z) return pc4 + 32'(off * 4);
        return pc4;
    endfunction

    // Monitor: compares presented fetch addresses and held instructions to the queues.
    initial begin
        logic  prev_req;
        logic  prev_valid;
        hold_t cur;
        logic [31:0] e;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        cur        = '{32'd0, 32'd0};
        forever begin
            @(negedge clk);
            if (bus.imem_req && !prev_req) begin
                if (fetch_q.size() == 0) begin
                    bound_fail("unexpected_fetch");
                end else begin
                    e = fetch_q.pop_front();
                    check("fetch_addr", bus.imem_addr, e);
                end
            end
            if (bus.instr_valid && !prev_valid) begin
                if (hold_q.size() == 0) begin
                    bound_fail("unexpected_valid");
                end else begin
                    cur = hold_q.pop_front();
                end
            end
            if (bus.instr_valid) begin
                check("hold_pc", bus.pc_out, cur.pc);
                check("hold_instr", bus.instr, cur.word);
                check("hold_op", {26'd0, bus.op}, {26'd0, cur.word[31:26]});
                check("hold_funct", {26'd0, bus.funct}, {26'd0, cur.word[5:0]});
                check("req_in_hold", {31'd0, bus.imem_req}, 32'd0);
            end
            prev_req   = bus.imem_req;
            prev_valid = bus.instr_valid;
        end
    end

    task automatic clear_inputs();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.instr_ack  = 1'b0;
        bus.stall      = 1'b0;
        bus.branch     = 1'b0;
        bus.jump       = 1'b0;
        bus.zero       = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where the first request is visible.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_fault", {31'd0, bus.fault}, 32'd0);
        check("rst_retired", {16'd0, bus.retired}, 32'd0);
        check("rst_pc", bus.pc_out, RST_PC);
        fetch_q.delete();
        hold_q.delete();
        model_pc  = RST_PC;
        retired_m = 16'd0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        fetch_q.push_back(model_pc);
        rst_n          = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.instr_ack  = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.instr_ack  = 1'b0;
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
    endtask

    task automatic do_instr(input logic [31:0] word, input bit br, input bit jp, input bit z,
                            input int nstall, input int delay, input bit abort);
        int n;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.imem_req) begin
            bound_fail("fetch_wait");
            return;
        end
        for (int i = 0; i < delay; i++) begin
            bus.instr_ack = 1'($urandom);
            bus.branch    = 1'($urandom);
            bus.jump      = 1'($urandom);
            bus.zero      = 1'($urandom);
            @(negedge clk);
        end
        bus.instr_ack  = 1'b0;
        bus.branch     = 1'b0;
        bus.jump       = 1'b0;
        bus.zero       = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        hold_q.push_back('{model_pc, word});
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = $urandom;
        check("valid_latency", {31'd0, bus.instr_valid}, 32'd1);
        check("retired_pre", {16'd0, bus.retired}, {16'd0, retired_m});
        if (abort) return;
        for (int i = 0; i < nstall; i++) begin
            bus.stall      = 1'b1;
            bus.instr_ack  = 1'b1;
            bus.branch     = 1'($urandom);
            bus.jump       = 1'($urandom);
            bus.zero       = 1'($urandom);
            bus.imem_ready = 1'($urandom);
            bus.imem_rdata = $urandom;
            @(negedge clk);
            check("retired_stall", {16'd0, bus.retired}, {16'd0, retired_m});
        end
        bus.stall      = 1'b0;
        bus.instr_ack  = 1'b1;
        bus.branch     = br;
        bus.jump       = jp;
        bus.zero       = z;
        bus.imem_ready = 1'b0;
        model_pc  = model_next(model_pc, word, br, jp, z);
        retired_m = retired_m + 16'd1;
        fetch_q.push_back(model_pc);
        @(negedge clk);
        bus.instr_ack = 1'b0;
        bus.branch    = 1'b0;
        bus.jump      = 1'b0;
        bus.zero      = 1'b0;
        check("retired", {16'd0, bus.retired}, {16'd0, retired_m});
    endtask

    initial begin
        int n;
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        clear_inputs();
        bus2.imem_ready = 1'b0;
        bus2.imem_rdata = 32'd0;
        bus2.instr_ack  = 1'b0;
        bus2.stall      = 1'b0;
        bus2.branch     = 1'b0;
        bus2.jump       = 1'b0;
        bus2.zero       = 1'b0;
        @(negedge clk);
        do_reset();

        do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0);    // pc 0 -> 4
        do_instr(32'h0800_0004, 0, 1, 0, 0, 1, 0);    // j -> 0x10
        do_instr(32'h1000_FFFE, 1, 0, 1, 0, 2, 0);    // beq taken -> 0x0C
        do_instr(32'h0800_0004, 0, 1, 0, 0, 0, 0);    // j -> 0x10
        do_instr(32'h1000_FFFE, 1, 0, 0, 0, 0, 0);    // beq not taken -> 0x14
        do_instr(32'h0123_4567, 0, 0, 0, 3, 1, 0);    // stalled retirement -> 0x18
        do_instr(32'h0800_0000, 1, 1, 1, 0, 0, 0);    // j wins over branch -> 0x00
        do_instr(32'h1000_FFFE, 1, 0, 1, 0, 0, 0);    // 4 - 8 -> 0xFFFF_FFFC
        do_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0);    // wraps -> 0
        do_instr(32'h0800_0010, 0, 1, 0, 0, 0, 0);    // j -> 0x40
        do_instr(32'h8C00_0004, 0, 0, 0, 0, 0, 1);    // held at 0x40, aborted by reset
        do_reset();

        for (int k = 0; k < 30; k++) begin
            do_instr($urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 4), 0);
        end

        do_reset();
        n = 0;
        while (bus.imem_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", 32'(n), 32'(TMO));
        check("fault_set", {31'd0, bus.fault}, 32'd1);
        check("fault_req", {31'd0, bus.imem_req}, 32'd0);
        check("fault_valid", {31'd0, bus.instr_valid}, 32'd0);
        bus.imem_ready = 1'b1;
        bus.instr_ack  = 1'b1;
        repeat (5) @(negedge clk);
        clear_inputs();
        check("fault_sticky", {31'd0, bus.fault}, 32'd1);
        do_reset();
        do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0);

        rst2_n = 1'b1;
        n = 0;
        while (!bus2.imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus2.imem_req) bound_fail("dut2_fetch_wait");
        check("dut2_reset_addr", bus2.imem_addr, 32'h1000_0008);
        bus2.imem_ready = 1'b1;
        bus2.imem_rdata = 32'h0800_0040;
        @(negedge clk);
        bus2.imem_ready = 1'b0;
        check("dut2_valid", {31'd0, bus2.instr_valid}, 32'd1);
        bus2.instr_ack = 1'b1;
        bus2.jump      = 1'b1;
        bus2.branch    = 1'b1;
        bus2.zero      = 1'b1;
        @(negedge clk);
        bus2.instr_ack = 1'b0;
        bus2.jump      = 1'b0;
        bus2.branch    = 1'b0;
        bus2.zero      = 1'b0;
        check("dut2_req", {31'd0, bus2.imem_req}, 32'd1);
        check("dut2_jump_addr", bus2.imem_addr, 32'h1000_0100);
        check("dut2_retired", {16'd0, bus2.retired}, 32'd1);

        repeat (3) @(negedge clk);
        check("queues_drained", 32'(fetch_q.size() + hold_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
